// File: rtl/decode_stage.sv
// decode_stage: ID stage of the RV32I pipeline.
//
// Takes the instruction/PC presented by IF, reads the register file through
// rs1/rs2 (data_1/data_2), applies the writeback bypass, builds the immediate,
// detects load-use hazards and registers one decoded bundle into the ID/EX
// pipeline register.
//
// Ports:
//   clk, rst                 clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready        IF -> ID handshake; instr, pc carry the payload
//   flush                    branch redirect: kills ID/EX and the incoming instr
//   rs1, rs2                 register file read addresses (instr[19:15], [24:20])
//   data_1, data_2           register file read data
//   wb_en, wb_rd, wb_data    writeback port, bypassed into the operands
//   ex_valid/ex_ready        ID -> EX handshake; ex_* carry the decoded bundle
//
// Handshake semantics (both sides): a transfer happens on a rising clk edge
// where valid and ready are both 1. valid never depends on ready. The ID/EX
// payload is held stable while ex_valid=1 and ex_ready=0 (unless flushed).
module decode_stage #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 32,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [WIDTH-1:0] pc,
    input  logic             flush,
    output logic [AW-1:0]    rs1,
    output logic [AW-1:0]    rs2,
    input  logic [WIDTH-1:0] data_1,
    input  logic [WIDTH-1:0] data_2,
    input  logic             wb_en,
    input  logic [AW-1:0]    wb_rd,
    input  logic [WIDTH-1:0] wb_data,
    output logic             ex_valid,
    input  logic             ex_ready,
    output logic [WIDTH-1:0] ex_pc,
    output logic [WIDTH-1:0] ex_op_a,
    output logic [WIDTH-1:0] ex_op_b,
    output logic [WIDTH-1:0] ex_imm,
    output logic [AW-1:0]    ex_rd,
    output logic [6:0]       ex_opcode,
    output logic [2:0]       ex_funct3,
    output logic             ex_funct7b5,
    output logic             ex_reg_write,
    output logic             ex_is_load,
    output logic             ex_illegal
);

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    logic [6:0]       opcode;
    logic [AW-1:0]    rd;
    logic             fmt_i, fmt_s, fmt_b, fmt_u, fmt_j;
    logic             illegal;
    logic [31:0]      imm32;
    logic [WIDTH-1:0] imm_w;
    logic             uses_rs1, uses_rs2;
    logic             reg_write;
    logic             hazard;
    logic [WIDTH-1:0] op_a, op_b;

    assign opcode = instr[6:0];
    assign rd     = AW'(instr[11:7]);
    assign rs1    = AW'(instr[19:15]);
    assign rs2    = AW'(instr[24:20]);

    // Format classification and immediate assembly.
    always_comb begin
        fmt_i   = 1'b0;
        fmt_s   = 1'b0;
        fmt_b   = 1'b0;
        fmt_u   = 1'b0;
        fmt_j   = 1'b0;
        illegal = 1'b0;
        imm32   = '0;
        unique case (opcode)
            OP_IMM, OP_LOAD, OP_JALR: begin
                fmt_i = 1'b1;
                imm32 = {{20{instr[31]}}, instr[31:20]};
            end
            OP_STORE: begin
                fmt_s = 1'b1;
                imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            end
            OP_BRANCH: begin
                fmt_b = 1'b1;
                imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25],
                         instr[11:8], 1'b0};
            end
            OP_LUI, OP_AUIPC: begin
                fmt_u = 1'b1;
                imm32 = {instr[31:12], 12'b0};
            end
            OP_JAL: begin
                fmt_j = 1'b1;
                imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20],
                         instr[30:21], 1'b0};
            end
            OP_REG, OP_FENCE, OP_SYSTEM: begin
                imm32 = '0;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

    assign imm_w = WIDTH'($signed(imm32));

    // Only sources the format actually reads may raise a load-use stall.
    assign uses_rs1  = !(fmt_u || fmt_j);
    assign uses_rs2  = !(fmt_i || fmt_u || fmt_j);
    assign reg_write = !illegal && !fmt_s && !fmt_b && (rd != '0);

    // The register file write lands on the same edge as the ID/EX capture,
    // so a matching writeback must be forwarded or the stale value is taken.
    always_comb begin
        op_a = data_1;
        op_b = data_2;
        if (rs1 == '0) begin
            op_a = '0;
        end else if (wb_en && (wb_rd == rs1)) begin
            op_a = wb_data;
        end
        if (rs2 == '0) begin
            op_b = '0;
        end else if (wb_en && (wb_rd == rs2)) begin
            op_b = wb_data;
        end
    end

    assign hazard = ex_valid && ex_is_load && (ex_rd != '0) && in_valid &&
                    ((uses_rs1 && (ex_rd == rs1)) || (uses_rs2 && (ex_rd == rs2)));

    assign in_ready = !flush && !hazard && (!ex_valid || ex_ready);

    // ID/EX pipeline register. Only ex_valid changes on flush or on a
    // consumed-but-not-refilled cycle; the payload is left as is.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_valid     <= 1'b0;
            ex_pc        <= '0;
            ex_op_a      <= '0;
            ex_op_b      <= '0;
            ex_imm       <= '0;
            ex_rd        <= '0;
            ex_opcode    <= '0;
            ex_funct3    <= '0;
            ex_funct7b5  <= 1'b0;
            ex_reg_write <= 1'b0;
            ex_is_load   <= 1'b0;
            ex_illegal   <= 1'b0;
        end else if (flush) begin
            ex_valid <= 1'b0;
        end else if (in_valid && in_ready) begin
            ex_valid     <= 1'b1;
            ex_pc        <= pc;
            ex_op_a      <= op_a;
            ex_op_b      <= op_b;
            ex_imm       <= imm_w;
            ex_rd        <= rd;
            ex_opcode    <= opcode;
            ex_funct3    <= instr[14:12];
            ex_funct7b5  <= instr[30];
            ex_reg_write <= reg_write;
            ex_is_load   <= (opcode == OP_LOAD);
            ex_illegal   <= illegal;
        end else if (ex_ready) begin
            ex_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: self-checking bench for decode_stage.
//
// A register file lives in the bench and answers rs1/rs2 reads from the
// instruction fields. A reference model predicts the ID/EX bundle from the
// instruction's meaning; a compare process checks the DUT against it on
// every falling edge. Directed cases pin known values, then random traffic
// runs with a small register range to provoke bypasses and hazards.
module tb_decode_stage;

    localparam int W  = 32;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   instr;
    logic [W-1:0]  pc;
    logic          flush;
    logic [AW-1:0] rs1, rs2;
    logic [W-1:0]  data_1, data_2;
    logic          wb_en;
    logic [AW-1:0] wb_rd;
    logic [W-1:0]  wb_data;
    logic          ex_valid;
    logic          ex_ready;
    logic [W-1:0]  ex_pc, ex_op_a, ex_op_b, ex_imm;
    logic [AW-1:0] ex_rd;
    logic [6:0]    ex_opcode;
    logic [2:0]    ex_funct3;
    logic          ex_funct7b5, ex_reg_write, ex_is_load, ex_illegal;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    decode_stage #(.WIDTH(W), .DEPTH(32)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .pc(pc), .flush(flush),
        .rs1(rs1), .rs2(rs2), .data_1(data_1), .data_2(data_2),
        .wb_en(wb_en), .wb_rd(wb_rd), .wb_data(wb_data),
        .ex_valid(ex_valid), .ex_ready(ex_ready),
        .ex_pc(ex_pc), .ex_op_a(ex_op_a), .ex_op_b(ex_op_b), .ex_imm(ex_imm),
        .ex_rd(ex_rd), .ex_opcode(ex_opcode), .ex_funct3(ex_funct3),
        .ex_funct7b5(ex_funct7b5), .ex_reg_write(ex_reg_write),
        .ex_is_load(ex_is_load), .ex_illegal(ex_illegal)
    );

    // ---------------- bench register file ----------------
    // x0 holds garbage on purpose: the decoder must force x0 reads to zero.
    logic [W-1:0] rf [32];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) rf[i] <= (i == 0) ? 32'hDEADBEEF : 32'h1000 + i;
        end else if (wb_en && wb_rd != 0) begin
            rf[wb_rd] <= wb_data;
        end
    end

    assign data_1 = rf[instr[19:15]];
    assign data_2 = rf[instr[24:20]];

    // ---------------- scoreboard helper ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40) $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        valid;
        logic [31:0] pc, op_a, op_b, imm;
        logic [4:0]  rd;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic        funct7b5, reg_write, is_load, illegal;
    } bundle_t;

    bundle_t m = '0;

    // Instruction format letter: I S B U J R (no immediate) or X (illegal).
    function automatic byte fmt_of(input logic [6:0] op);
        case (op)
            7'h13, 7'h03, 7'h67: return "I";
            7'h23:               return "S";
            7'h63:               return "B";
            7'h37, 7'h17:        return "U";
            7'h6F:               return "J";
            7'h33, 7'h0F, 7'h73: return "R";
            default:             return "X";
        endcase
    endfunction

    // Value register r will hold once this edge's writeback has landed.
    function automatic logic [31:0] reg_val(input int r);
        if (r == 0) return 32'h0;
        if (wb_en && int'(wb_rd) == r) return wb_data;
        return rf[r];
    endfunction

    function automatic logic [31:0] imm_of(input logic [31:0] ins);
        int s, hi, sgn;
        s   = $signed(ins);
        sgn = s >>> 31;
        case (fmt_of(ins[6:0]))
            "I": return s >>> 20;
            "S": begin hi = s >>> 25; return hi * 32 + int'(ins[11:7]); end
            "B": return sgn * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32
                        + int'(ins[11:8]) * 2;
            "U": return ins & 32'hFFFFF000;
            "J": return sgn * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
                        + int'(ins[30:21]) * 2;
            default: return 32'h0;
        endcase
    endfunction

    function automatic bundle_t predict();
        bundle_t b;
        byte f;
        f = fmt_of(instr[6:0]);
        b.valid     = 1'b1;
        b.pc        = pc;
        b.op_a      = reg_val(int'(instr[19:15]));
        b.op_b      = reg_val(int'(instr[24:20]));
        b.imm       = imm_of(instr);
        b.rd        = instr[11:7];
        b.opcode    = instr[6:0];
        b.funct3    = instr[14:12];
        b.funct7b5  = instr[30];
        b.illegal   = (f == "X");
        b.is_load   = (instr[6:0] == 7'h03);
        b.reg_write = (f != "X") && (f != "S") && (f != "B") && (instr[11:7] != 0);
        return b;
    endfunction

    function automatic logic exp_in_ready();
        byte f;
        logic r1, r2, stall;
        f  = fmt_of(instr[6:0]);
        r1 = (f != "U") && (f != "J");
        r2 = (f != "I") && (f != "U") && (f != "J");
        stall = m.valid && m.is_load && m.rd != 0 && in_valid &&
                ((r1 && m.rd == instr[19:15]) || (r2 && m.rd == instr[24:20]));
        return !flush && !stall && (!m.valid || ex_ready);
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m = '0;
        end else if (flush) begin
            m.valid = 1'b0;
        end else if (in_valid && exp_in_ready()) begin
            m = predict();
        end else if (ex_ready) begin
            m.valid = 1'b0;
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        bundle_t e;
        e = rst ? '0 : m;
        chk("rs1", 32'(rs1), 32'(instr[19:15]));
        chk("rs2", 32'(rs2), 32'(instr[24:20]));
        chk("in_ready", 32'(in_ready), 32'(rst ? !flush : exp_in_ready()));
        chk("ex_valid", 32'(ex_valid), 32'(e.valid));
        if (rst || e.valid) begin
            chk("ex_pc", ex_pc, e.pc);
            chk("ex_op_a", ex_op_a, e.op_a);
            chk("ex_op_b", ex_op_b, e.op_b);
            chk("ex_imm", ex_imm, e.imm);
            chk("ex_rd", 32'(ex_rd), 32'(e.rd));
            chk("ex_opcode", 32'(ex_opcode), 32'(e.opcode));
            chk("ex_funct3", 32'(ex_funct3), 32'(e.funct3));
            chk("ex_funct7b5", 32'(ex_funct7b5), 32'(e.funct7b5));
            chk("ex_reg_write", 32'(ex_reg_write), 32'(e.reg_write));
            chk("ex_is_load", 32'(ex_is_load), 32'(e.is_load));
            chk("ex_illegal", 32'(ex_illegal), 32'(e.illegal));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] p);
        in_valid = 1'b1;
        instr    = ins;
        pc       = p;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  ops [14];
        logic [31:0] ins;
        ops = '{7'h13, 7'h03, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F,
                7'h33, 7'h0F, 7'h73, 7'h03, 7'h7F, 7'h2B};
        ins        = $urandom;
        ins[6:0]   = ops[$urandom_range(0, 13)];
        ins[11:7]  = 5'($urandom_range(0, 3));
        ins[19:15] = 5'($urandom_range(0, 3));
        ins[24:20] = 5'($urandom_range(0, 3));
        return ins;
    endfunction

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; flush = 1'b0; ex_ready = 1'b1;
        wb_en = 1'b0; wb_rd = '0; wb_data = '0;
        issue(32'h00500093, 32'h100);          // addi x1,x0,5

        // Reset holds the bundle empty even with a valid instruction offered.
        repeat (3) step();
        chk("rst_ex_valid", 32'(ex_valid), 32'h0);
        chk("rst_ex_imm", ex_imm, 32'h0);
        chk("rst_ex_rd", 32'(ex_rd), 32'h0);
        chk("rst_ex_reg_write", 32'(ex_reg_write), 32'h0);
        rst = 1'b0;
        step();
        chk("first_valid", 32'(ex_valid), 32'h1);
        chk("first_imm", ex_imm, 32'd5);
        chk("first_rd", 32'(ex_rd), 32'd1);
        chk("first_op_a", ex_op_a, 32'h0);
        chk("first_reg_write", 32'(ex_reg_write), 32'h1);

        // Bypass: x2=4, x1=7, then add x3,x2,x1 while x1 is rewritten to 9.
        in_valid = 1'b0;
        wb_en = 1'b1; wb_rd = 5'd2; wb_data = 32'd4;
        step();
        wb_rd = 5'd1; wb_data = 32'd7;
        step();
        issue(32'h001101B3, 32'h104);
        wb_rd = 5'd1; wb_data = 32'd9;
        step();
        chk("byp_op_a", ex_op_a, 32'd4);
        chk("byp_op_b", ex_op_b, 32'd9);
        issue(32'h000001B3, 32'h108);          // add x3,x0,x0
        wb_rd = 5'd0; wb_data = 32'h55;
        step();
        chk("x0_op_a", ex_op_a, 32'h0);
        chk("x0_op_b", ex_op_b, 32'h0);
        wb_en = 1'b0;

        // Load-use: lw x2,0(x1) followed by add x3,x2,x1.
        issue(32'h0000A103, 32'h10C);
        step();
        chk("lw_is_load", 32'(ex_is_load), 32'h1);
        issue(32'h001101B3, 32'h110);
        #1;
        chk("hz_in_ready", 32'(in_ready), 32'h0);
        step();
        chk("hz_bubble", 32'(ex_valid), 32'h0);
        chk("hz_retry_ready", 32'(in_ready), 32'h1);
        step();
        chk("hz_issue_valid", 32'(ex_valid), 32'h1);
        chk("hz_issue_rd", 32'(ex_rd), 32'd3);
        chk("hz_issue_pc", ex_pc, 32'h110);

        // Immediates.
        issue(32'h0030A423, 32'h114);          // sw x3,8(x1)
        step();
        chk("sw_imm", ex_imm, 32'd8);
        chk("sw_reg_write", 32'(ex_reg_write), 32'h0);
        issue(32'hFE208EE3, 32'h118);          // beq x1,x2,-4
        step();
        chk("beq_imm", ex_imm, 32'hFFFFFFFC);
        issue(32'h12345037, 32'h11C);          // lui x0,0x12345
        step();
        chk("lui_imm", ex_imm, 32'h12345000);

        // Backpressure: bundle frozen, nothing accepted.
        ex_ready = 1'b0;
        issue(32'h00100113, 32'h200);
        repeat (3) begin
            step();
            chk("bp_pc", ex_pc, 32'h11C);
            chk("bp_valid", 32'(ex_valid), 32'h1);
            chk("bp_in_ready", 32'(in_ready), 32'h0);
        end
        flush = 1'b1;
        step();
        chk("flush_valid", 32'(ex_valid), 32'h0);
        flush = 1'b0; in_valid = 1'b0; ex_ready = 1'b1;
        step();
        chk("flush_dropped", 32'(ex_valid), 32'h0);

        // Unsupported opcode still flows through, flagged.
        issue(32'h000000FF, 32'h300);
        step();
        chk("ill_valid", 32'(ex_valid), 32'h1);
        chk("ill_flag", 32'(ex_illegal), 32'h1);
        chk("ill_reg_write", 32'(ex_reg_write), 32'h0);

        // Reset in the middle of a stall clears immediately.
        ex_ready = 1'b0;
        issue(32'h00500093, 32'h304);
        step();
        rst = 1'b1;
        #1;
        chk("midrst_valid", 32'(ex_valid), 32'h0);
        chk("midrst_pc", ex_pc, 32'h0);
        step();
        rst = 1'b0; ex_ready = 1'b1;
        issue(32'h00700093, 32'h400);
        step();
        chk("post_rst_valid", 32'(ex_valid), 32'h1);
        chk("post_rst_imm", ex_imm, 32'd7);
        chk("post_rst_pc", ex_pc, 32'h400);

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            in_valid = ($urandom_range(0, 3) != 0);
            ex_ready = ($urandom_range(0, 3) != 0);
            flush    = ($urandom_range(0, 15) == 0);
            wb_en    = $urandom_range(0, 1) == 1;
            wb_rd    = 5'($urandom_range(0, 3));
            wb_data  = $urandom;
            instr    = rand_instr();
            pc       = $urandom & 32'hFFFFFFFC;
            step();
        end

        in_valid = 1'b0; flush = 1'b0; wb_en = 1'b0;
        repeat (3) step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
- ID stage of the RV32I pipeline. Takes the fetched instruction and PC from IF.
- Drives the register file read addresses rs1/rs2 and consumes its data_1/data_2.
- Applies the writeback bypass, generates the immediate, detects load-use hazards, and registers one decoded bundle into an ID/EX pipeline register with a valid/ready handshake.

Parameters:
- WIDTH, 32, datapath/register width
- DEPTH, 32, number of architectural registers; address width is clog2(DEPTH)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous active-high reset
- in_valid  in  1  IF holds a valid instruction
- in_ready  out  1  ID accepts instruction this cycle
- instr  in  32  instruction word
- pc  in  WIDTH  PC of instr
- flush  in  1  kill ID/EX contents and incoming instruction (branch redirect)
- rs1  out  clog2(DEPTH)  register file read address 1, equals instr[19:15]
- rs2  out  clog2(DEPTH)  register file read address 2, equals instr[24:20]
- data_1  in  WIDTH  register file read data 1
- data_2  in  WIDTH  register file read data 2
- wb_en  in  1  writeback write enable (same signal as register file write_en)
- wb_rd  in  clog2(DEPTH)  writeback destination
- wb_data  in  WIDTH  writeback data
- ex_valid  out  1  ID/EX bundle valid
- ex_ready  in  1  EX consumes bundle this cycle
- ex_pc, ex_op_a, ex_op_b, ex_imm  out  WIDTH  registered PC, rs1 value, rs2 value, immediate
- ex_rd  out  clog2(DEPTH)  destination register
- ex_opcode  out  7  instr[6:0]
- ex_funct3  out  3  instr[14:12]
- ex_funct7b5  out  1  instr[30]
- ex_reg_write  out  1  instruction writes rd (rd != 0)
- ex_is_load  out  1  opcode 0000011
- ex_illegal  out  1  unsupported opcode

Behaviour:
- Reset (async, rst=1): ex_valid=0 and every ex_* output = 0, immediately and held while rst=1. rs1/rs2 are combinational from instr, with no reset.
- Operand read: x0 reads are forced to 0.
  - Bypass: if wb_en && wb_rd==rs1 && rs1!=0, op_a = wb_data; otherwise op_a = data_1. Same rule for op_b using rs2/data_2.
  - The register file write lands at the same edge, so without the bypass the old value would be captured.
- Immediate by opcode:
  - I-type (0010011, 0000011, 1100111): sext(instr[31:20]).
  - S-type (0100011): sext({[31:25],[11:7]}).
  - B-type (1100011): sext({[31],[7],[30:25],[11:8],0}).
  - U-type (0110111, 0010111): {[31:12],12'b0}.
  - J-type (1101111): sext({[31],[19:12],[20],[30:21],0}).
  - R-type (0110011), FENCE (0001111), SYSTEM (1110011): imm = 0.
  - Any other opcode: ex_illegal=1, ex_reg_write=0, bundle still passes with valid=1.
- ex_reg_write = 0 for S-type and B-type, and whenever rd==0.
- Load-use hazard: hazard = ex_valid && ex_is_load && ex_rd!=0 && in_valid && (ex_rd==rs1 || ex_rd==rs2).
  - A source is counted only if its format uses it: rs2 unused for I/U/J; rs1 unused for U/J.
- in_ready = !flush && !hazard && (!ex_valid || ex_ready).
- ID/EX register update at the clk edge, first matching rule wins:
  1. flush: ex_valid <= 0; the incoming instruction is dropped (not accepted).
  2. in_valid && in_ready: load the new bundle, ex_valid <= 1.
  3. ex_ready (bundle consumed, nothing loaded, including a hazard cycle): ex_valid <= 0, which inserts a bubble.
  4. Otherwise: hold all ex_* outputs stable, ex_valid included.
- Latency: an instruction accepted at edge N is visible on ex_* after edge N. Throughput is 1 per cycle when ex_ready=1 and there is no hazard. A hazard costs exactly 1 bubble.
- Simultaneous wb_en to the same register as a hazard: the hazard still stalls; the bypass applies on the retry cycle if wb is still active.
- rst asserted mid-stall or mid-flush: outputs clear at once. After release the first accepted instruction proceeds normally.

Test Plan:
- Reset: rst=1 with in_valid=1, instr=0x00500093 -> ex_valid=0, all ex_*=0. Release, then 1 edge -> ex_valid=1, ex_imm=5, ex_rd=1, ex_op_a=0, ex_reg_write=1.
- Bypass: register file x1=7, wb_en=1, wb_rd=1, wb_data=9, instr add x3,x2,x1 (0x001101B3), x2=4 -> ex_op_a=4, ex_op_b=9. Same case with wb_rd=0: instr add x3,x0,x0 gives ex_op_a=0.
- Load-use: lw x2,0(x1) (0x0000A103) accepted, then add x3,x2,x1 with ex_ready=1 -> in_ready=0 for 1 cycle, ex_valid=0 for one cycle, then add issues with ex_rd=3.
- Immediates: sw x3,8(x1) (0x0030A423) -> ex_imm=8, ex_reg_write=0. beq x1,x2,-4 (0xFE208EE3) -> ex_imm=0xFFFFFFFC. lui-style 0x12345037 -> ex_imm=0x12345000.
- Backpressure/flush: ex_ready=0 for 3 cycles -> ex_* stable, in_ready=0. Then flush=1 with in_valid=1 -> ex_valid=0 next edge and that instruction is not accepted. Opcode 0x7F -> ex_illegal=1, ex_reg_write=0.
